rf_writeback_queue: RTL

- Write-side companion to the 8 x 16-bit register file.
- Collects register writes from the ALU result path and the load/pop result path, and buffers them in an in-order FIFO.
- Drains at most one entry per cycle into the register-file write port.
- Exposes a two-port forwarding lookup so decode-stage readers get the youngest pending value for a register before it is committed.

---
 rtl/rf_writeback_queue_if.sv | 43 ++++
 rtl/rf_writeback_queue.sv | 102 ++++++++++
 2 files changed

// File: rtl/rf_writeback_queue_if.sv
// Bus bundle for the register-file writeback queue: producer requests,
// register-file write port, forwarding lookup and status.
interface rf_writeback_queue_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              in_ready;
  logic              drain_stall;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic              fwd_hit_1;
  logic [DATA_W-1:0] fwd_data_1;
  logic              fwd_hit_2;
  logic [DATA_W-1:0] fwd_data_2;
  logic [CNT_W-1:0]  count;
  logic              overflow_err;

  modport master (
    output alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
           drain_stall, rd_addr_1, rd_addr_2,
    input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit_1, fwd_data_1,
           fwd_hit_2, fwd_data_2, count, overflow_err
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data, ld_valid, ld_addr, ld_data,
           drain_stall, rd_addr_1, rd_addr_2,
    output in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit_1, fwd_data_1,
           fwd_hit_2, fwd_data_2, count, overflow_err
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order writeback FIFO between the ALU/load result paths and the register
// file, draining one entry per cycle with a two-port youngest-match forward.
module rf_writeback_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  rf_writeback_queue_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              in_ready, rf_we, ld_en, alu_en, not_empty;
  logic [PTR_W-1:0]  alu_slot;
  logic [CNT_W-1:0]  free_slots;
  logic [1:0]        n_enq;

  assign free_slots = CNT_W'(DEPTH) - count_q;
  assign in_ready   = free_slots >= CNT_W'(2);
  assign not_empty  = count_q != '0;
  assign ld_en      = in_ready && bus.ld_valid;
  assign alu_en     = in_ready && bus.alu_valid;
  // The load entry is the older of a same-cycle pair, so ALU lands behind it.
  assign alu_slot   = ld_en ? tail_q + PTR_W'(1) : tail_q;
  assign rf_we      = not_empty && !bus.drain_stall;

  always_comb begin
    n_enq   = {1'b0, ld_en} + {1'b0, alu_en};
    valid_d = valid_q;
    if (ld_en)  valid_d[tail_q]   = 1'b1;
    if (alu_en) valid_d[alu_slot] = 1'b1;
    if (rf_we)  valid_d[head_q]   = 1'b0;
    tail_d  = tail_q + PTR_W'(n_enq);
    head_d  = rf_we ? head_q + PTR_W'(1) : head_q;
    count_d = count_q + CNT_W'(n_enq) - CNT_W'(rf_we);
    ovf_d   = ovf_q | (!in_ready && (bus.ld_valid || bus.alu_valid));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_en) begin
      addr_q[tail_q] <= bus.ld_addr;
      data_q[tail_q] <= bus.ld_data;
    end
    if (alu_en) begin
      addr_q[alu_slot] <= bus.alu_addr;
      data_q[alu_slot] <= bus.alu_data;
    end
  end

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx            = '0;
    bus.fwd_hit_1  = 1'b0;
    bus.fwd_data_1 = '0;
    bus.fwd_hit_2  = 1'b0;
    bus.fwd_data_2 = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && addr_q[idx] == bus.rd_addr_1) begin
        bus.fwd_hit_1  = 1'b1;
        bus.fwd_data_1 = data_q[idx];
      end
      if (valid_q[idx] && addr_q[idx] == bus.rd_addr_2) begin
        bus.fwd_hit_2  = 1'b1;
        bus.fwd_data_2 = data_q[idx];
      end
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.rf_we        = rf_we;
  assign bus.rf_waddr     = not_empty ? addr_q[head_q] : '0;
  assign bus.rf_wdata     = not_empty ? data_q[head_q] : '0;
  assign bus.count        = count_q;
  assign bus.overflow_err = ovf_q;
endmodule
